// File: rtl/xc_malu.sv
// Multi-cycle multiply / packed-multiply / divide / add-sub unit with IDLE-BUSY-DONE handshake.
// Define XC_MALU_DIVIDE_EN to build the iterative divider; otherwise div/rem finish in 2 cycles with 0.
module xc_malu (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] rs3,
    input  logic        valid,
    input  logic        flush,
    input  logic        insn_mul,
    input  logic        insn_pmul,
    input  logic        insn_div,
    input  logic        insn_rem,
    input  logic        insn_macc,
    input  logic        insn_madd,
    input  logic        insn_msub,
    input  logic [4:0]  pw,
    input  logic        lhs_sign,
    input  logic        rhs_sign,
    input  logic        carryless,
    output logic        ready,
    output logic [31:0] result_1,
    output logic [31:0] result_0
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [63:0] acc, acc_nxt, mul_nxt, res_nxt;
    logic [63:0] div_init, div_nxt, div_res;
    logic        is_div, is_long, mul_neg;
    logic [2:0]  lw;
    logic [5:0]  w;
    logic [4:0]  base;
    logic [31:0] op_a, op_b, lane_mask;
    logic [63:0] term;

    // Lane k's 2w-bit product lives at acc[2wk +: 2w]; split it into low/high lane halves.
    function automatic logic [63:0] unpack(input logic [63:0] p, input logic [2:0] l);
        logic [31:0] r0, r1;
        logic [5:0]  ww, j, k2;
        ww = 6'd1 << l;
        r0 = '0;
        r1 = '0;
        for (int b = 0; b < 32; b++) begin
            j     = 6'(b) & (ww - 6'd1);
            k2    = (6'(b) >> l) << (l + 3'd1);
            r0[b] = p[k2 + j];
            r1[b] = p[k2 + ww + j];
        end
        return {r1, r0};
    endfunction

    always_comb begin
        lw = 3'd5;
        if (insn_pmul) begin
            case (pw)
                5'b00010: lw = 3'd4;
                5'b00100: lw = 3'd3;
                5'b01000: lw = 3'd2;
                5'b10000: lw = 3'd1;
                default:  lw = 3'd5;
            endcase
        end
    end

    // Shifting the masked lane of rs1 left by the bit index lands it in its widened slot.
    assign w         = 6'd1 << lw;
    assign base      = count & ~(w[4:0] - 5'd1);
    assign lane_mask = (32'hFFFF_FFFF >> (6'd32 - w)) << base;
    assign op_a      = (insn_mul && !carryless && lhs_sign && rs1[31]) ? -rs1 : rs1;
    assign op_b      = (insn_mul && !carryless && rhs_sign && rs2[31]) ? -rs2 : rs2;
    assign term      = {32'b0, op_a & lane_mask} << count;
    assign mul_nxt   = op_b[count] ? (carryless ? (acc ^ term) : (acc + term)) : acc;
    assign mul_neg   = insn_mul && !carryless && ((lhs_sign && rs1[31]) != (rhs_sign && rs2[31]));

`ifdef XC_MALU_DIVIDE_EN
    logic [31:0] dvd_mag, dvs_mag, sub, quo, rem;
    logic [32:0] rem33;
    logic        ge;

    assign is_div   = insn_div | insn_rem;
    assign dvd_mag  = (rhs_sign && rs1[31]) ? -rs1 : rs1;
    assign dvs_mag  = (rhs_sign && rs2[31]) ? -rs2 : rs2;
    assign div_init = {32'b0, dvd_mag};
    // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
    assign rem33    = {acc[63:32], acc[31]};
    assign ge       = rem33 >= {1'b0, dvs_mag};
    assign sub      = rem33[31:0] - dvs_mag;
    assign div_nxt  = ge ? {sub, acc[30:0], 1'b1} : {rem33[31:0], acc[30:0], 1'b0};
    assign quo      = div_nxt[31:0];
    assign rem      = div_nxt[63:32];

    always_comb begin
        div_res = {(rhs_sign && rs1[31]) ? -rem : rem,
                   (rhs_sign && (rs1[31] ^ rs2[31])) ? -quo : quo};
        if (rs2 == 32'd0) div_res = {rs1, 32'hFFFF_FFFF};
    end
`else
    assign is_div   = 1'b0;
    assign div_init = '0;
    assign div_nxt  = '0;
    assign div_res  = '0;
`endif

    assign is_long = insn_mul | insn_pmul | is_div;
    assign acc_nxt = is_div ? div_nxt : mul_nxt;

    always_comb begin
        res_nxt = '0;
        if (insn_mul)                   res_nxt = mul_neg ? -mul_nxt : mul_nxt;
        else if (insn_pmul)             res_nxt = unpack(mul_nxt, lw);
        else if (insn_div || insn_rem)  res_nxt = div_res;
        else if (insn_madd)             res_nxt = {32'b0, rs1} + {32'b0, rs2} + {63'b0, rs3[0]};
        else if (insn_msub)             res_nxt = {32'b0, rs1} - {32'b0, rs2} - {63'b0, rs3[0]};
        else if (insn_macc)             res_nxt = {rs2, rs1} + {32'b0, rs3};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid && !flush) state_nxt = BUSY;
            BUSY: begin
                if (!valid || flush)                  state_nxt = IDLE;
                else if (!is_long || count == 5'd31)  state_nxt = DONE;
            end
            DONE: if (!valid || flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            result_1 <= '0;
            result_0 <= '0;
        end else if (state == IDLE) begin
            count <= '0;
            acc   <= is_div ? div_init : '0;
        end else if (state == BUSY) begin
            count <= count + 5'd1;
            acc   <= acc_nxt;
            if (state_nxt == DONE) {result_1, result_0} <= res_nxt;
        end
    end

    assign ready = (state == DONE);
endmodule

// File: tb/tb_xc_malu.sv
// Bench for xc_malu: fixed vector table, random ops against an arithmetic model, handshake corners.
module tb_xc_malu;
    logic        clock = 1'b0, reset = 1'b1;
    logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
    logic        valid = 1'b0, flush = 1'b0;
    logic        insn_mul = 0, insn_pmul = 0, insn_div = 0, insn_rem = 0;
    logic        insn_macc = 0, insn_madd = 0, insn_msub = 0;
    logic [4:0]  pw = 5'b00001;
    logic        lhs_sign = 0, rhs_sign = 0, carryless = 0;
    logic        ready;
    logic [31:0] result_1, result_0;

    xc_malu dut (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .valid(valid), .flush(flush),
        .insn_mul(insn_mul), .insn_pmul(insn_pmul), .insn_div(insn_div), .insn_rem(insn_rem),
        .insn_macc(insn_macc), .insn_madd(insn_madd), .insn_msub(insn_msub),
        .pw(pw), .lhs_sign(lhs_sign), .rhs_sign(rhs_sign), .carryless(carryless),
        .ready(ready), .result_1(result_1), .result_0(result_0)
    );

    always #5 clock = ~clock;

`ifdef XC_MALU_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int OP_MUL = 0, OP_PMUL = 1, OP_DIV = 2, OP_REM = 3;
    localparam int OP_MACC = 4, OP_MADD = 5, OP_MSUB = 6, OP_NONE = 7;
    localparam logic [4:0] PW32 = 5'b00001, PW16 = 5'b00010, PW8 = 5'b00100,
                           PW4 = 5'b01000, PW2 = 5'b10000;

    typedef struct {
        int          op;
        logic [31:0] a, b, c;
        logic [4:0]  pw;
        logic        ls, rs, cl;
        logic [63:0] exp;
    } vec_t;

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int op, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                logic [4:0] p, logic ls, logic rs, logic cl, logic [63:0] e);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.pw = p;
        v.ls = ls; v.rs = rs; v.cl = cl; v.exp = e;
        return v;
    endfunction

    function automatic int exp_lat(int op);
        if (op == OP_MUL || op == OP_PMUL) return 33;
        if ((op == OP_DIV || op == OP_REM) && DIV_EN) return 33;
        return 2;
    endfunction

    function automatic logic [63:0] clmul(logic [63:0] a, logic [63:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 32; i++) if (b[i]) r ^= a << i;
        return r;
    endfunction

    // Reference built straight from the arithmetic definitions of each operation.
    function automatic logic [63:0] model(vec_t v);
        logic signed [63:0] sa, sb;
        logic [63:0] la, lb, p, mask;
        logic [31:0] r0, r1;
        int wd;
        case (v.op)
            OP_MUL: begin
                if (v.cl) return clmul({32'b0, v.a}, {32'b0, v.b});
                sa = v.ls ? {{32{v.a[31]}}, v.a} : {32'b0, v.a};
                sb = v.rs ? {{32{v.b[31]}}, v.b} : {32'b0, v.b};
                return sa * sb;
            end
            OP_PMUL: begin
                case (v.pw)
                    PW16: wd = 16;
                    PW8:  wd = 8;
                    PW4:  wd = 4;
                    PW2:  wd = 2;
                    default: wd = 32;
                endcase
                mask = (64'd1 << wd) - 64'd1;
                r0 = '0; r1 = '0;
                for (int k = 0; k < 32 / wd; k++) begin
                    la = ({32'b0, v.a} >> (k * wd)) & mask;
                    lb = ({32'b0, v.b} >> (k * wd)) & mask;
                    p  = v.cl ? clmul(la, lb) : la * lb;
                    r0 |= 32'((p & mask) << (k * wd));
                    r1 |= 32'(((p >> wd) & mask) << (k * wd));
                end
                return {r1, r0};
            end
            OP_DIV, OP_REM: begin
                if (!DIV_EN) return 64'd0;
                if (v.b == 0) return {v.a, 32'hFFFF_FFFF};
                if (v.rs) begin
                    if (v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                    return {32'($signed(v.a) % $signed(v.b)), 32'($signed(v.a) / $signed(v.b))};
                end
                return {v.a % v.b, v.a / v.b};
            end
            OP_MADD: return {32'b0, v.a} + {32'b0, v.b} + {63'b0, v.c[0]};
            OP_MSUB: return {32'b0, v.a} - {32'b0, v.b} - {63'b0, v.c[0]};
            OP_MACC: return {v.b, v.a} + {32'b0, v.c};
            default: return 64'd0;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        rs1 = v.a; rs2 = v.b; rs3 = v.c; pw = v.pw;
        lhs_sign = v.ls; rhs_sign = v.rs; carryless = v.cl;
        insn_mul  = (v.op == OP_MUL);  insn_pmul = (v.op == OP_PMUL);
        insn_div  = (v.op == OP_DIV);  insn_rem  = (v.op == OP_REM);
        insn_macc = (v.op == OP_MACC); insn_madd = (v.op == OP_MADD);
        insn_msub = (v.op == OP_MSUB);
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        do begin
            @(posedge clock); #1;
            edges++;
        end while (!ready && edges < 60);
    endtask

    task automatic run(input vec_t v, output int edges, output logic [63:0] res);
        @(negedge clock);
        drive(v);
        valid = 1'b1;
        wait_ready(edges);
        res = {result_1, result_0};
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock); #1;
    endtask

    vec_t        tbl[19];
    vec_t        v, vm, vadd;
    int          edges;
    logic [63:0] res, held;

    initial begin
        tbl[0]  = mk(OP_MUL,  32'h0000FFFF, 32'h0000FFFF, 0, PW32, 0, 0, 0, 64'h00000000_FFFE0001);
        tbl[1]  = mk(OP_MUL,  32'hFFFFFFFF, 32'h00000002, 0, PW32, 1, 1, 0, 64'hFFFFFFFF_FFFFFFFE);
        tbl[2]  = mk(OP_MUL,  32'hFFFFFFFF, 32'h00000002, 0, PW32, 1, 0, 0, 64'hFFFFFFFF_FFFFFFFE);
        tbl[3]  = mk(OP_MUL,  32'hFFFFFFFF, 32'h00000002, 0, PW32, 0, 1, 0, 64'h00000001_FFFFFFFE);
        tbl[4]  = mk(OP_MUL,  32'h00000003, 32'h00000003, 0, PW32, 1, 1, 1, 64'h00000000_00000005);
        tbl[5]  = mk(OP_PMUL, 32'h00030002, 32'h00050004, 0, PW16, 0, 0, 0, 64'h00000000_000F0008);
        tbl[6]  = mk(OP_PMUL, 32'hFFFF0000, 32'hFFFF0000, 0, PW16, 0, 0, 0, 64'hFFFE0000_00010000);
        tbl[7]  = mk(OP_PMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, PW32, 0, 0, 0, 64'hFFFFFFFE_00000001);
        tbl[8]  = mk(OP_PMUL, 32'h00010000, 32'h00010000, 0, 5'b00011, 0, 0, 0, 64'h00000001_00000000);
        tbl[9]  = mk(OP_PMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, PW2, 0, 0, 0, 64'hAAAAAAAA_55555555);
        tbl[10] = mk(OP_PMUL, 32'h03030303, 32'h03030303, 0, PW8, 0, 0, 1, 64'h00000000_05050505);
        tbl[11] = mk(OP_MADD, 32'hFFFFFFFF, 32'h00000001, 1, PW32, 0, 0, 0, 64'h00000001_00000001);
        tbl[12] = mk(OP_MSUB, 32'h00000000, 32'h00000001, 1, PW32, 0, 0, 0, 64'hFFFFFFFF_FFFFFFFE);
        tbl[13] = mk(OP_MACC, 32'hFFFFFFFF, 32'h00000000, 1, PW32, 0, 0, 0, 64'h00000001_00000000);
        tbl[14] = mk(OP_NONE, 32'h12345678, 32'h9ABCDEF0, 7, PW32, 0, 0, 0, 64'h0);
        tbl[15] = mk(OP_DIV,  32'd7, 32'd2, 0, PW32, 0, 0, 0, DIV_EN ? 64'h00000001_00000003 : 64'h0);
        tbl[16] = mk(OP_DIV,  32'd7, 32'd0, 0, PW32, 0, 0, 0, DIV_EN ? 64'h00000007_FFFFFFFF : 64'h0);
        tbl[17] = mk(OP_REM,  32'h80000000, 32'hFFFFFFFF, 0, PW32, 0, 1, 0,
                     DIV_EN ? 64'h00000000_80000000 : 64'h0);
        tbl[18] = mk(OP_DIV,  32'hFFFFFFF9, 32'd2, 0, PW32, 0, 1, 0,
                     DIV_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'h0);

        // Reset state, then first accept on the first edge with reset low.
        vadd = tbl[11];
        drive(vadd);
        valid = 1'b1;
        @(posedge clock); #1;
        check("reset_ready", {63'b0, ready}, 64'd0);
        check("reset_result", {result_1, result_0}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_ready(edges);
        check("first_accept_lat", edges, 2);
        check("first_accept_res", {result_1, result_0}, 64'h00000001_00000001);
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 19; i++) begin
            run(tbl[i], edges, res);
            check($sformatf("vec%0d_lat", i), edges, exp_lat(tbl[i].op));
            check($sformatf("vec%0d_res", i), res, tbl[i].exp);
        end

        // Results hold while ready; flush with valid&&ready drops to IDLE, next valid accepted.
        vm = tbl[0];
        @(negedge clock);
        drive(vm);
        valid = 1'b1;
        wait_ready(edges);
        held = {result_1, result_0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("hold_ready", {63'b0, ready}, 64'd1);
            check("hold_result", {result_1, result_0}, 64'h00000000_FFFE0001);
        end
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        check("flush_done_ready", {63'b0, ready}, 64'd0);
        @(negedge clock);
        flush = 1'b0;
        drive(vadd);
        wait_ready(edges);
        check("after_flush_lat", edges, 2);
        check("after_flush_res", {result_1, result_0}, 64'h00000001_00000001);
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock); #1;

        // Flush mid-multiply restarts the operation from scratch.
        @(negedge clock);
        drive(vm);
        valid = 1'b1;
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        check("flush_mid_ready", {63'b0, ready}, 64'd0);
        @(negedge clock);
        flush = 1'b0;
        wait_ready(edges);
        check("flush_mid_restart_lat", edges, 33);
        check("flush_mid_restart_res", {result_1, result_0}, 64'h00000000_FFFE0001);
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock); #1;

        // Reset at edge 10 of a multiply clears results and abandons it.
        @(negedge clock);
        drive(vm);
        valid = 1'b1;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_mid_ready", {63'b0, ready}, 64'd0);
        check("reset_mid_result", {result_1, result_0}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_ready(edges);
        check("reset_mid_restart_lat", edges, 33);
        check("reset_mid_restart_res", {result_1, result_0}, 64'h00000000_FFFE0001);
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock); #1;

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [4:0] pws[5];
            pws[0] = PW32; pws[1] = PW16; pws[2] = PW8; pws[3] = PW4; pws[4] = PW2;
            v.op = int'($urandom_range(0, 7));
            v.a  = $urandom;
            v.b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            v.c  = $urandom;
            v.pw = ($urandom_range(0, 5) == 0) ? 5'($urandom) : pws[$urandom_range(0, 4)];
            v.ls = 1'($urandom);
            v.rs = 1'($urandom);
            v.cl = 1'($urandom);
            v.exp = model(v);
            run(v, edges, res);
            check($sformatf("rand%0d_op%0d_lat", i, v.op), edges, exp_lat(v.op));
            check($sformatf("rand%0d_op%0d_res", i, v.op), res, v.exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
